motion_diff_bbox: RTL and testbench
===================================

// Module: motion_diff_bbox
// PURPOSE
// Frame-difference motion detector. It takes the live 8-bit gray pixel stream and the
// co-located pixel of the previous frame, which it pulls from the SDRAM read-port-1 FIFO.
// Each pixel yields a 1-bit motion mask (|cur-prev| > threshold); the mask stream feeds
// the SDRAM write-port-2 / display path. Per frame, it accumulates the motion bounding
// box and the moving-pixel count, and publishes both at frame end.
// PARAMETERS
// IMG_HDISP   640  active pixels per line (x range 0..IMG_HDISP-1)
// IMG_VDISP   480  active lines per frame (y range 0..IMG_VDISP-1)
// MIN_PIXELS  16   minimum moving-pixel count for box_valid=1
// PORTS
// clk              in   1   pixel clock (cam_pclk domain)
// rst              in   1   synchronous reset, active-high
// per_frame_vsync  in   1   high for the whole frame; rise=frame start, fall=frame end
// per_frame_href   in   1   high during an active line
// per_frame_clken  in   1   pixel strobe; counted only while per_frame_href=1
// per_img_gray     in   8   current-frame gray pixel
// diff_threshold   in   8   motion threshold (strict greater-than)
// prev_rd          out  1   read request to previous-frame FIFO (normal mode, data +1 cycle)
// prev_gray        in   8   previous-frame pixel, valid the cycle after prev_rd
// prev_empty       in   1   previous-frame FIFO empty
// post_frame_vsync out  1   vsync delayed 2 cycles
// post_frame_href  out  1   href delayed 2 cycles
// post_frame_clken out  1   clken&href delayed 2 cycles
// post_img_bit     out  1   motion mask for the pixel
// box_xmin/xmax    out  10  bounding-box columns of last completed frame
// box_ymin/ymax    out  10  bounding-box rows of last completed frame
// motion_cnt       out  19  moving pixels in last completed frame (saturating)
// box_valid        out  1   motion_cnt >= MIN_PIXELS for last completed frame
// frame_done       out  1   1-cycle pulse when box/count outputs update
// underrun         out  1   sticky: prev_empty seen at a read this frame
// BEHAVIOUR
// - Reset: all outputs 0. Internal state on reset: x/y counters 0, accumulator cleared,
//   first_frame=1. Reset mid-frame: the partial frame is discarded with no frame_done;
//   detection restarts at the next vsync rise, and that frame is treated as the first frame.
// - prev_rd = per_frame_clken & per_frame_href & ~prev_empty & ~rst (combinational).
// - Pipeline, 2 cycles fixed:
//   - S1 registers cur gray, x, y, pixel-valid and the empty-at-read flag.
//   - S2 computes d = |cur - prev| with a 9-bit subtract and registers the mask:
//     mask = (d > diff_threshold) & ~first_frame & ~empty_at_read.
//   - post_* control signals are delayed 2 cycles to stay aligned with the mask.
//   - post_img_bit = 0 whenever post_frame_clken = 0.
// - Coordinates:
//   - x increments per valid pixel and clears on the href falling edge.
//   - y increments on the href falling edge and clears on the vsync rise.
//   - x saturates at IMG_HDISP-1 and y saturates at IMG_VDISP-1. Pixels beyond either
//     limit produce mask=0 and are not accumulated.
// - Accumulator:
//   - At vsync rise: xmin=IMG_HDISP-1, xmax=0, ymin=IMG_VDISP-1, ymax=0, cnt=0,
//     underrun cleared.
//   - On each S2 mask=1: min/max updated and cnt+1, saturating at 19'h7FFFF.
// - Frame end: FSM IDLE -> ACTIVE on vsync rise, ACTIVE -> FLUSH on vsync fall.
//   - FLUSH waits 2 cycles for pipeline drain, then -> PUBLISH.
//   - PUBLISH (1 cycle) does the following, then -> IDLE:
//     - latches box_*/motion_cnt;
//     - sets box_valid = (cnt >= MIN_PIXELS);
//     - pulses frame_done;
//     - clears first_frame.
//   - When box_valid=0, box_* are still latched (raw accumulator values).
//   - A vsync rise during FLUSH or PUBLISH completes the publish first, then starts the
//     new frame's accumulation, losing no pixels (the pipeline carries them).
// - Underrun: prev_empty at a read slot -> no read issued, pixel masked 0, underrun=1
//   until the next vsync rise. No retry is attempted, so FIFO alignment is maintained
//   by the SDRAM read reset.
// TESTING
// 1 Reset, then idle inputs -> all outputs 0; prev_rd=0; frame_done never pulses.
// 2 Frame 1 with any data -> frame_done pulses once about 3 cycles after vsync fall;
//   motion_cnt=0, box_valid=0 (first frame suppressed).
// 3 Frame 2 with prev=cur except the block x=100..119, y=50..59 at diff 50, thr=20 ->
//   box=(100,119,50,59), motion_cnt=200, box_valid=1; post_img_bit=1 exactly on those
//   pixels, 2 cycles after input.
// 4 diff exactly 20 with thr=20 -> mask 0; diff 21 -> mask 1.
//   Blocks giving cnt=15 vs cnt=16 -> box_valid 0 vs 1.
// 5 Assert prev_empty for 8 pixels mid-line -> no prev_rd for those pixels, mask 0,
//   underrun=1; underrun clears at the next vsync rise.
// 6 Assert rst at line 200 of a moving frame -> outputs 0 next cycle; the next full
//   frame is treated as the first frame (cnt=0); the frame after reports the correct box.

Source files
------------

// File: rtl/motion_diff_bbox.sv
// Frame-difference motion detector: per-pixel motion mask against the previous frame,
// plus a per-frame bounding box and moving-pixel count published at frame end.
module motion_diff_bbox #(
    parameter int unsigned IMG_HDISP  = 640,
    parameter int unsigned IMG_VDISP  = 480,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [7:0]  per_img_gray,
    input  logic [7:0]  diff_threshold,
    output logic        prev_rd,
    input  logic [7:0]  prev_gray,
    input  logic        prev_empty,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic        post_img_bit,
    output logic [9:0]  box_xmin,
    output logic [9:0]  box_xmax,
    output logic [9:0]  box_ymin,
    output logic [9:0]  box_ymax,
    output logic [18:0] motion_cnt,
    output logic        box_valid,
    output logic        frame_done,
    output logic        underrun
);

    localparam logic [9:0]  XLast   = 10'(IMG_HDISP - 1);
    localparam logic [9:0]  YLast   = 10'(IMG_VDISP - 1);
    localparam logic [18:0] CntSat  = 19'h7FFFF;
    localparam logic [18:0] MinCnt  = 19'(MIN_PIXELS);

    typedef enum logic [1:0] {StIdle, StActive, StFlush, StPublish} state_e;

    logic pix_in;
    logic vsync_q, href_q;
    logic vs_rise, vs_fall, href_fall;

    assign pix_in    = per_frame_clken & per_frame_href;
    assign prev_rd   = pix_in & ~prev_empty & ~rst;
    assign vs_rise   = per_frame_vsync & ~vsync_q;
    assign vs_fall   = ~per_frame_vsync & vsync_q;
    assign href_fall = ~per_frame_href & href_q;

    // Edge detectors; vsync_q resets high so a reset inside a frame never fakes a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b1;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= per_frame_vsync;
            href_q  <= per_frame_href;
        end
    end

    logic [9:0] x_q, y_q;
    logic       x_ovf_q, y_ovf_q;

    // Saturating pixel coordinates; the ovf flags mark pixels beyond the active window.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            x_ovf_q <= 1'b0;
            y_q     <= '0;
            y_ovf_q <= 1'b0;
        end else begin
            if (href_fall) begin
                x_q     <= '0;
                x_ovf_q <= 1'b0;
            end else if (pix_in) begin
                if (x_q == XLast) x_ovf_q <= 1'b1;
                else              x_q     <= x_q + 10'd1;
            end
            if (vs_rise) begin
                y_q     <= '0;
                y_ovf_q <= 1'b0;
            end else if (href_fall) begin
                if (y_q == YLast) y_ovf_q <= 1'b1;
                else              y_q     <= y_q + 10'd1;
            end
        end
    end

    logic       s1_pix_q, s1_inr_q, s1_empty_q, s1_vs_q, s1_hr_q;
    logic [7:0] s1_gray_q;
    logic [9:0] s1_x_q, s1_y_q;

    // Stage 1: hold the current pixel and its context while the FIFO returns prev_gray.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_pix_q   <= 1'b0;
            s1_inr_q   <= 1'b0;
            s1_empty_q <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_hr_q    <= 1'b0;
            s1_gray_q  <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            s1_pix_q   <= pix_in;
            s1_inr_q   <= ~x_ovf_q & ~y_ovf_q;
            s1_empty_q <= prev_empty;
            s1_vs_q    <= per_frame_vsync;
            s1_hr_q    <= per_frame_href;
            s1_gray_q  <= per_img_gray;
            s1_x_q     <= x_q;
            s1_y_q     <= y_q;
        end
    end

    logic [8:0] diff9;
    logic [7:0] abs_d;
    logic       mask_d;
    logic       first_frame_q;

    // Stage 2: absolute difference and threshold; invalid or unreadable pixels mask to 0.
    always_comb begin
        diff9  = {1'b0, s1_gray_q} - {1'b0, prev_gray};
        abs_d  = diff9[8] ? (~diff9[7:0] + 8'd1) : diff9[7:0];
        mask_d = s1_pix_q & s1_inr_q & ~s1_empty_q & ~first_frame_q &
                 (abs_d > diff_threshold);
    end

    // Output stage: control delayed two cycles to stay aligned with the mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_bit     <= 1'b0;
        end else begin
            post_frame_vsync <= s1_vs_q;
            post_frame_href  <= s1_hr_q;
            post_frame_clken <= s1_pix_q;
            post_img_bit     <= mask_d;
        end
    end

    state_e state_q, state_d;
    logic   flush_q, pend_q;

    // Frame FSM next state; pend_q remembers a vsync rise that arrived during the flush.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (vs_rise) state_d = StActive;
            StActive:  if (vs_fall) state_d = StFlush;
            StFlush:   if (flush_q) state_d = StPublish;
            StPublish: state_d = (pend_q | vs_rise) ? StActive : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Frame FSM state, two-cycle flush counter and pending-start flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            flush_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= (state_q == StFlush) & ~flush_q;
            pend_q  <= (state_q == StFlush) & (pend_q | vs_rise);
        end
    end

    logic [9:0]  xmin_q, xmax_q, ymin_q, ymax_q, xmin_d, xmax_d, ymin_d, ymax_d;
    logic [18:0] cnt_q, cnt_d;

    // Accumulator update; re-armed on publish so a pixel landing that cycle is kept.
    always_comb begin
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        cnt_d  = cnt_q;
        if ((vs_rise && state_q == StIdle) || state_q == StPublish) begin
            xmin_d = XLast;
            xmax_d = '0;
            ymin_d = YLast;
            ymax_d = '0;
            cnt_d  = '0;
        end
        if (mask_d && state_q != StIdle) begin
            if (s1_x_q < xmin_d) xmin_d = s1_x_q;
            if (s1_x_q > xmax_d) xmax_d = s1_x_q;
            if (s1_y_q < ymin_d) ymin_d = s1_y_q;
            if (s1_y_q > ymax_d) ymax_d = s1_y_q;
            if (cnt_d != CntSat) cnt_d = cnt_d + 19'd1;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
            cnt_q  <= '0;
        end else begin
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            cnt_q  <= cnt_d;
        end
    end

    // Publish results of the completed frame and end first-frame suppression.
    always_ff @(posedge clk) begin
        if (rst) begin
            box_xmin      <= '0;
            box_xmax      <= '0;
            box_ymin      <= '0;
            box_ymax      <= '0;
            motion_cnt    <= '0;
            box_valid     <= 1'b0;
            frame_done    <= 1'b0;
            first_frame_q <= 1'b1;
        end else begin
            frame_done <= (state_q == StPublish);
            if (state_q == StPublish) begin
                box_xmin      <= xmin_q;
                box_xmax      <= xmax_q;
                box_ymin      <= ymin_q;
                box_ymax      <= ymax_q;
                motion_cnt    <= cnt_q;
                box_valid     <= (cnt_q >= MinCnt);
                first_frame_q <= 1'b0;
            end
        end
    end

    // Sticky underrun flag; a new empty read wins over the frame-start clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (pix_in & prev_empty) begin
            underrun <= 1'b1;
        end else if (vs_rise) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_motion_diff_bbox.sv
// Directed bench for motion_diff_bbox on a reduced 128x64 frame geometry.
module tb_motion_diff_bbox;

    localparam int H = 128;
    localparam int V = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
    logic [7:0]  per_img_gray = '0, thr = 8'd20, prev_gray = '0;
    logic        prev_empty = 1'b0;
    logic        prev_rd, post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit;
    logic [9:0]  box_xmin, box_xmax, box_ymin, box_ymax;
    logic [18:0] motion_cnt;
    logic        box_valid, frame_done, underrun;

    int vectors = 0, errors = 0;
    int cyc = 0, fall_cyc = 0, done_at = -1, done_cnt = 0;
    int pipe_err = 0, rd_err = 0, ones = 0;
    logic [3:0]  p1 = '0, p2 = '0;
    logic        rd_q = 1'b0;
    logic [7:0]  rd_data = '0;
    logic        first_m = 1'b1, rst_prev = 1'b0, rst_seen = 1'b0, ur_s = 1'b0, ur_start = 1'b0;
    logic [65:0] outs_s = '0, rst_snap = '0;
    logic [59:0] box_s;
    int ax0 = -1, ax1 = -2, ay0 = -1, ay1 = -2, ad = 0;
    int bx0 = -1, bx1 = -2, by0 = -1, by1 = -2, bd = 0;

    motion_diff_bbox #(.IMG_HDISP(H), .IMG_VDISP(V), .MIN_PIXELS(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_gray     (per_img_gray),
        .diff_threshold   (thr),
        .prev_rd          (prev_rd),
        .prev_gray        (prev_gray),
        .prev_empty       (prev_empty),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_bit     (post_img_bit),
        .box_xmin         (box_xmin),
        .box_xmax         (box_xmax),
        .box_ymin         (box_ymin),
        .box_ymax         (box_ymax),
        .motion_cnt       (motion_cnt),
        .box_valid        (box_valid),
        .frame_done       (frame_done),
        .underrun         (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cur_px(input int x, input int y);
        return 8'((x + 3 * y) % 128 + 64);
    endfunction

    function automatic int diff_at(input int x, input int y);
        if (x >= ax0 && x <= ax1 && y >= ay0 && y <= ay1) return ad;
        if (x >= bx0 && x <= bx1 && y >= by0 && y <= by1) return bd;
        return 0;
    endfunction

    // Previous pixel differs by +d on odd columns and -d on even ones.
    function automatic logic [7:0] prev_px(input int x, input int y);
        logic [7:0] c;
        c = cur_px(x, y);
        if (x % 2 == 1) return c + 8'(diff_at(x, y));
        return c - 8'(diff_at(x, y));
    endfunction

    task automatic set_blocks(input int a0, a1, a2, a3, a4, b0, b1, b2, b3, b4);
        ax0 = a0; ax1 = a1; ay0 = a2; ay1 = a3; ad = a4;
        bx0 = b0; bx1 = b1; by0 = b2; by1 = b3; bd = b4;
    endtask

    // One clock: drive inputs, check the mask stream at negedge, model the prev FIFO.
    task automatic step(input logic v, h, c, e, r, input int x, input int y);
        logic pix, m;
        logic [7:0] cp, pp;
        int adiff;
        pix = c & h;
        cp = cur_px(x, y);
        pp = prev_px(x, y);
        rst = r;
        per_frame_vsync = v;
        per_frame_href = h;
        per_frame_clken = c;
        per_img_gray = cp;
        prev_empty = e;
        prev_gray = rd_q ? rd_data : 8'h00;
        @(negedge clk);
        if (prev_rd !== (pix & ~e & ~r)) rd_err++;
        if ({post_img_bit, post_frame_clken, post_frame_href, post_frame_vsync} !== p2)
            pipe_err++;
        if (post_img_bit === 1'b1) ones++;
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
        end
        outs_s = {post_img_bit, post_frame_clken, post_frame_href, post_frame_vsync,
                  box_xmin, box_xmax, box_ymin, box_ymax, motion_cnt,
                  box_valid, frame_done, underrun};
        ur_s = underrun;
        if (rst_prev) rst_snap = outs_s;
        rst_prev = r;
        adiff = (cp > pp) ? int'(cp) - int'(pp) : int'(pp) - int'(cp);
        m = pix && !e && !r && !first_m && (x < H) && (y < V) && (adiff > int'(thr));
        if (r) begin
            p1 = '0;
            p2 = '0;
            first_m = 1'b1;
            rst_seen = 1'b1;
        end else begin
            p2 = p1;
            p1 = {m, pix, h, v};
        end
        rd_q = prev_rd;
        rd_data = pp;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int nl, input int np, input bit gaps,
                             input int e_line, input int e_x, input int e_n, input int rst_line);
        int x, k;
        logic c, e;
        pipe_err = 0; rd_err = 0; ones = 0; done_cnt = 0; done_at = -1; rst_seen = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        ur_start = ur_s;
        for (int y = 0; y < nl; y++) begin
            if (y == rst_line) step(1, 0, 0, 0, 1, 0, 0);
            x = 0;
            k = 0;
            while (x < np) begin
                c = !(gaps && (k % 5 == 4));
                e = c && (y == e_line) && (x >= e_x) && (x < e_x + e_n);
                step(1, 1, c, e, 0, x, y);
                if (c) x++;
                k++;
            end
            repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        end
        fall_cyc = cyc;
        repeat (10) step(0, 0, 0, 0, 0, 0, 0);
        if (!rst_seen) first_m = 1'b0;
        box_s = {box_xmin, box_xmax, box_ymin, box_ymax, motion_cnt, box_valid};
    endtask

    task automatic test_reset();
        rd_err = 0;
        repeat (3) step(0, 1, 1, 0, 1, 0, 0);
        pipe_err = 0; done_cnt = 0;
        repeat (8) step(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (outs_s !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", outs_s);
        end
        vectors++;
        if (rd_err !== 0) begin
            errors++; $display("FAIL reset_prev_rd: %0d bad cycles, want 0", rd_err);
        end
        vectors++;
        if (done_cnt !== 0 || pipe_err !== 0) begin
            errors++; $display("FAIL reset_idle: done=%0d pipe=%0d want 0 0", done_cnt, pipe_err);
        end
    endtask

    task automatic test_first_frame();
        set_blocks(2, 5, 2, 5, 50, -1, -2, -1, -2, 0);
        run_frame(16, 32, 0, -1, 0, 0, -1);
        vectors++;
        if (done_cnt !== 1 || done_at - fall_cyc < 2 || done_at - fall_cyc > 5) begin
            errors++;
            $display("FAIL first_done: pulses=%0d delay=%0d want 1 pulse delay 2..5",
                     done_cnt, done_at - fall_cyc);
        end
        vectors++;
        if (box_s !== {10'd127, 10'd0, 10'd63, 10'd0, 19'd0, 1'b0}) begin
            errors++; $display("FAIL first_box: got %h want suppressed raw box", box_s);
        end
        vectors++;
        if (pipe_err !== 0 || rd_err !== 0) begin
            errors++; $display("FAIL first_stream: pipe=%0d rd=%0d want 0 0", pipe_err, rd_err);
        end
    endtask

    task automatic test_block_motion();
        set_blocks(100, 119, 50, 59, 50, -1, -2, -1, -2, 0);
        run_frame(60, 120, 1, -1, 0, 0, -1);
        vectors++;
        if (box_s !== {10'd100, 10'd119, 10'd50, 10'd59, 19'd200, 1'b1}) begin
            errors++; $display("FAIL block_box: got %h want box 100..119 x 50..59 cnt 200", box_s);
        end
        vectors++;
        if (pipe_err !== 0) begin
            errors++; $display("FAIL block_mask_stream: %0d bad cycles, want 0", pipe_err);
        end
        vectors++;
        if (ones !== 200 || done_cnt !== 1) begin
            errors++; $display("FAIL block_ones: ones=%0d done=%0d want 200 1", ones, done_cnt);
        end
    endtask

    task automatic test_threshold();
        set_blocks(4, 8, 3, 5, 21, 20, 27, 10, 12, 20);
        run_frame(16, 32, 0, -1, 0, 0, -1);
        vectors++;
        if (box_s !== {10'd4, 10'd8, 10'd3, 10'd5, 19'd15, 1'b0}) begin
            errors++; $display("FAIL thr_cnt15: got %h want box 4..8 x 3..5 cnt 15 invalid", box_s);
        end
        vectors++;
        if (pipe_err !== 0 || ones !== 15) begin
            errors++; $display("FAIL thr_stream15: pipe=%0d ones=%0d want 0 15", pipe_err, ones);
        end
        set_blocks(10, 13, 6, 9, 21, 20, 27, 10, 12, 20);
        run_frame(16, 32, 0, -1, 0, 0, -1);
        vectors++;
        if (box_s !== {10'd10, 10'd13, 10'd6, 10'd9, 19'd16, 1'b1}) begin
            errors++; $display("FAIL thr_cnt16: got %h want box 10..13 x 6..9 cnt 16 valid", box_s);
        end
        vectors++;
        if (pipe_err !== 0 || ones !== 16) begin
            errors++; $display("FAIL thr_stream16: pipe=%0d ones=%0d want 0 16", pipe_err, ones);
        end
    endtask

    task automatic test_underrun();
        set_blocks(8, 15, 4, 5, 50, -1, -2, -1, -2, 0);
        run_frame(16, 32, 0, 4, 10, 8, -1);
        vectors++;
        if (box_s !== {10'd8, 10'd15, 10'd4, 10'd5, 19'd10, 1'b0}) begin
            errors++; $display("FAIL underrun_box: got %h want box 8..15 x 4..5 cnt 10", box_s);
        end
        vectors++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL underrun_flag: got %b want 1", underrun);
        end
        vectors++;
        if (rd_err !== 0 || pipe_err !== 0) begin
            errors++; $display("FAIL underrun_stream: rd=%0d pipe=%0d want 0 0", rd_err, pipe_err);
        end
        set_blocks(-1, -2, -1, -2, 0, -1, -2, -1, -2, 0);
        run_frame(16, 32, 0, -1, 0, 0, -1);
        vectors++;
        if (ur_start !== 1'b0 || underrun !== 1'b0) begin
            errors++; $display("FAIL underrun_clear: start=%b end=%b want 0 0", ur_start, underrun);
        end
        vectors++;
        if (box_s !== {10'd127, 10'd0, 10'd63, 10'd0, 19'd0, 1'b0}) begin
            errors++; $display("FAIL still_box: got %h want empty raw box", box_s);
        end
    endtask

    task automatic test_saturation();
        set_blocks(126, 131, 62, 65, 50, -1, -2, -1, -2, 0);
        run_frame(66, 132, 0, -1, 0, 0, -1);
        vectors++;
        if (box_s !== {10'd126, 10'd127, 10'd62, 10'd63, 19'd4, 1'b0}) begin
            errors++; $display("FAIL sat_box: got %h want box 126..127 x 62..63 cnt 4", box_s);
        end
        vectors++;
        if (pipe_err !== 0 || ones !== 4) begin
            errors++; $display("FAIL sat_stream: pipe=%0d ones=%0d want 0 4", pipe_err, ones);
        end
    endtask

    task automatic test_reset_midframe();
        set_blocks(4, 7, 2, 5, 50, -1, -2, -1, -2, 0);
        run_frame(48, 32, 0, -1, 0, 0, 40);
        vectors++;
        if (rst_snap !== '0) begin
            errors++; $display("FAIL midrst_outputs: got %h want 0", rst_snap);
        end
        vectors++;
        if (done_cnt !== 0 || box_s !== '0 || pipe_err !== 0) begin
            errors++;
            $display("FAIL midrst_discard: done=%0d box=%h pipe=%0d want 0 0 0",
                     done_cnt, box_s, pipe_err);
        end
        run_frame(16, 32, 0, -1, 0, 0, -1);
        vectors++;
        if (done_cnt !== 1 || box_s !== {10'd127, 10'd0, 10'd63, 10'd0, 19'd0, 1'b0}) begin
            errors++; $display("FAIL midrst_first: done=%0d box=%h want 1 suppressed", done_cnt, box_s);
        end
        run_frame(16, 32, 0, -1, 0, 0, -1);
        vectors++;
        if (box_s !== {10'd4, 10'd7, 10'd2, 10'd5, 19'd16, 1'b1}) begin
            errors++; $display("FAIL midrst_recover: got %h want box 4..7 x 2..5 cnt 16", box_s);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_first_frame();
        test_block_motion();
        test_threshold();
        test_underrun();
        test_saturation();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
